// File: rtl/serial_add_seq.sv
`default_nettype none
// ============================================================================
// Module   : serial_add_seq
// Purpose  : Sequencer for a 1-bit serial adder. A start pulse in IDLE loads
//            the parallel operands into internal shift registers. The block
//            then runs WIDTH shift cycles, LSB first, through a full-adder
//            slice with a registered carry, collects the sum into a result
//            shift register and signals completion with a one-cycle done.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   WIDTH     operand/result width in bits (2..32)
// Ports:
//   clk       in   rising-edge clock
//   reset     in   synchronous, active-high reset
//   start     in   request a new addition, sampled only in IDLE
//   a, b      in   WIDTH-bit operands, captured on an accepted start
//   cin       in   carry-in, captured on an accepted start
//   sub       in   (SERIAL_ADD_SUB_EN only) 1 = compute a-b, captured on start
//   busy      out  high in SHIFT and DONE
//   shift_en  out  high in every SHIFT cycle (datapath shift strobe)
//   ser_sum   out  combinational sum bit of the current SHIFT cycle, else 0
//   done      out  one-cycle completion pulse
//   result    out  sum, valid from done until the next accepted start
//   cout      out  final carry, valid from done until the next accepted start
// Build option:
//   SERIAL_ADD_SUB_EN  adds the sub port (two's-complement subtraction)
// ============================================================================
module serial_add_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             shift_en,
  output logic             ser_sum,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] C_LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t             state_q,    state_d;
  logic [WIDTH-1:0]   a_sr_q,     a_sr_d;
  logic [WIDTH-1:0]   b_sr_q,     b_sr_d;
  logic               carry_q,    carry_d;
  logic [CNT_W-1:0]   cnt_q,      cnt_d;
  logic [WIDTH-1:0]   result_q,   result_d;
  logic               cout_q,     cout_d;
  logic               busy_q,     busy_d;
  logic               shift_en_q, shift_en_d;
  logic               done_q,     done_d;

  logic               sum_bit;
  logic               carry_bit;
  logic               sub_sel;

`ifdef SERIAL_ADD_SUB_EN
  assign sub_sel = sub;
`else
  assign sub_sel = 1'b0;
`endif

  // Full-adder bit slice on the current LSBs and the registered carry.
  assign sum_bit   = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
  assign carry_bit = (a_sr_q[0] & b_sr_q[0]) | (carry_q & (a_sr_q[0] ^ b_sr_q[0]));

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    cout_d   = cout_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_sr_d  = a;
          // Subtraction is a + ~b + 1; the +1 rides in on the carry register.
          b_sr_d  = sub_sel ? ~b : b;
          carry_d = sub_sel ? 1'b1 : cin;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        result_d = {sum_bit, result_q[WIDTH-1:1]};
        carry_d  = carry_bit;
        a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
        b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == C_LAST_CNT) begin
          cout_d  = carry_bit;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Status outputs are registered, so they are decoded from the next state.
    busy_d     = (state_d != ST_IDLE);
    shift_en_d = (state_d == ST_SHIFT);
    done_d     = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      a_sr_q     <= '0;
      b_sr_q     <= '0;
      carry_q    <= 1'b0;
      cnt_q      <= '0;
      result_q   <= '0;
      cout_q     <= 1'b0;
      busy_q     <= 1'b0;
      shift_en_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_sr_q     <= a_sr_d;
      b_sr_q     <= b_sr_d;
      carry_q    <= carry_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
      cout_q     <= cout_d;
      busy_q     <= busy_d;
      shift_en_q <= shift_en_d;
      done_q     <= done_d;
    end
  end

  assign busy     = busy_q;
  assign shift_en = shift_en_q;
  assign done     = done_q;
  assign result   = result_q;
  assign cout     = cout_q;
  // Gated so the sum bit reads 0 outside SHIFT.
  assign ser_sum  = (state_q == ST_SHIFT) & sum_bit;

endmodule
`default_nettype wire

// File: tb/tb_serial_add_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_add_seq
// Purpose  : Self-checking bench for serial_add_seq (WIDTH=4 and WIDTH=8
//            instances) against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_add_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;

  logic       start4, cin4;
  logic [3:0] a4, b4;
  logic       busy4, shift_en4, ser_sum4, done4, cout4;
  logic [3:0] result4;

  logic       start8, cin8;
  logic [7:0] a8, b8;
  logic       busy8, shift_en8, ser_sum8, done8, cout8;
  logic [7:0] result8;

`ifdef SERIAL_ADD_SUB_EN
  logic sub4;
  logic sub8;
`endif

  int checks   = 0;
  int failures = 0;

  serial_add_seq #(.WIDTH(4)) dut4 (
    .clk      (clk),
    .reset    (reset),
    .start    (start4),
    .a        (a4),
    .b        (b4),
    .cin      (cin4),
`ifdef SERIAL_ADD_SUB_EN
    .sub      (sub4),
`endif
    .busy     (busy4),
    .shift_en (shift_en4),
    .ser_sum  (ser_sum4),
    .done     (done4),
    .result   (result4),
    .cout     (cout4)
  );

  serial_add_seq #(.WIDTH(8)) dut8 (
    .clk      (clk),
    .reset    (reset),
    .start    (start8),
    .a        (a8),
    .b        (b8),
    .cin      (cin8),
`ifdef SERIAL_ADD_SUB_EN
    .sub      (sub8),
`endif
    .busy     (busy8),
    .shift_en (shift_en8),
    .ser_sum  (ser_sum8),
    .done     (done8),
    .result   (result8),
    .cout     (cout8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One WIDTH=4 operation checked against plain arithmetic.
  // inject=1 pulses a second start during the 2nd SHIFT cycle.
  task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic c,
                      input logic s, input bit inject);
    logic [4:0] full;
    if (s) full = {1'b0, a} + {1'b0, ~b} + 5'd1;
    else   full = {1'b0, a} + {1'b0, b} + {4'd0, c};
    a4 = a; b4 = b; cin4 = c; start4 = 1'b1;
`ifdef SERIAL_ADD_SUB_EN
    sub4 = s;
`endif
    tick();
    start4 = 1'b0;
    a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
    for (int i = 0; i < 4; i++) begin
      check("shift_en4", shift_en4, 1);
      check("busy4_shift", busy4, 1);
      check("ser_sum4", ser_sum4, full[i]);
      check("done4_early", done4, 0);
      if (inject && i == 1) begin
        start4 = 1'b1; a4 = 4'd1; b4 = 4'd1;
      end
      tick();
      start4 = 1'b0;
    end
    check("done4", done4, 1);
    check("busy4_done", busy4, 1);
    check("shift_en4_done", shift_en4, 0);
    check("ser_sum4_done", ser_sum4, 0);
    check("result4", result4, full[3:0]);
    check("cout4", cout4, full[4]);
    tick();
    check("done4_clear", done4, 0);
    check("busy4_idle", busy4, 0);
    check("result4_hold", result4, full[3:0]);
    check("cout4_hold", cout4, full[4]);
    tick();
    check("done4_none", done4, 0);
    check("busy4_none", busy4, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone;
    int nshift;
    int first_done;
    int last_done;
    int gap_ok;

    reset = 1'b1;
    start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    sub4 = 1'b0;
    sub8 = 1'b0;
`endif
    tick(); tick(); tick();

    // Reset state
    check("rst_busy4", busy4, 0);
    check("rst_shift_en4", shift_en4, 0);
    check("rst_done4", done4, 0);
    check("rst_ser_sum4", ser_sum4, 0);
    check("rst_result4", result4, 0);
    check("rst_cout4", cout4, 0);
    check("rst_busy8", busy8, 0);
    check("rst_result8", result8, 0);
    reset = 1'b0;
    tick();

    // Directed additions
    run4(4'b0011, 4'b0101, 1'b0, 1'b0, 1'b0);
    run4(4'b1111, 4'b0001, 1'b0, 1'b0, 1'b0);
    run4(4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);

    // Start pulsed during SHIFT is ignored
    run4(4'b0110, 4'b0011, 1'b0, 1'b0, 1'b1);

    // Reset in the 2nd SHIFT cycle aborts the operation
    a4 = 4'b1010; b4 = 4'b0110; cin4 = 1'b0; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    tick();
    check("abort_in_shift", shift_en4, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy4", busy4, 0);
    check("abort_shift_en4", shift_en4, 0);
    check("abort_result4", result4, 0);
    check("abort_cout4", cout4, 0);
    check("abort_done4", done4, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("abort_no_done4", done4, 0);
    end
    run4(4'b1010, 4'b0110, 1'b0, 1'b0, 1'b0);

    // Randomized additions
    for (int n = 0; n < 10; n++) begin
      run4(4'($urandom), 4'($urandom), 1'($urandom), 1'b0, 1'b0);
    end

`ifdef SERIAL_ADD_SUB_EN
    run4(4'b0101, 4'b0011, 1'b0, 1'b1, 1'b0);
    run4(4'b0011, 4'b0101, 1'b1, 1'b1, 1'b0);
    for (int n = 0; n < 6; n++) begin
      run4(4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    end
`endif

    // WIDTH=8 with start held high: back-to-back operations every 10 cycles
    a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    ndone = 0; nshift = 0; first_done = -1; last_done = -1; gap_ok = 1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (shift_en8 === 1'b1) nshift++;
      if (done8 === 1'b1) begin
        ndone++;
        check("result8", result8, 8'h00);
        check("cout8", cout8, 1);
        if (first_done < 0) first_done = k;
        else if (k - last_done != 10) gap_ok = 0;
        last_done = k;
      end
    end
    start8 = 1'b0;
    check("w8_first_done_cycle", first_done, 9);
    check("w8_done_count", ndone, 4);
    check("w8_period", gap_ok, 1);
    check("w8_shift_cycles", nshift, 32);
    tick(); tick(); tick();
    check("w8_idle_busy", busy8, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
